// File: rtl/alu_mult_ctrl.sv
// ---------------------------------------------------------------------------
// alu_mult_ctrl
//
// Sequential shift-and-add multiplier controller. It computes the unsigned
// product of two WIDTH-bit operands in WIDTH cycles. It does this by driving
// one external WIDTH-bit ripple adder, performing one add per cycle.
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   request, accepted only while idle
//   a         in   multiplicand, captured when start is accepted
//   b         in   multiplier, captured when start is accepted
//   busy      out  high while the multiply is running
//   done      out  one-cycle pulse, product valid
//   product   out  last completed result, held until the next completion
//   add_a     out  adder operand A (accumulator)
//   add_b     out  adder operand B (multiplicand or zero)
//   add_cin   out  adder carry-in, always 0
//   add_sum   in   adder sum, combinational from add_a/add_b/add_cin
//   add_cout  in   adder carry-out
// ---------------------------------------------------------------------------
module alu_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WIDTH-1:0]    m_reg;
  logic [WIDTH-1:0]    acc;
  logic [WIDTH-1:0]    q;
  logic [CNT_W-1:0]    cnt;
  logic [2*WIDTH-1:0]  product_reg;
  logic [WIDTH-1:0]    acc_shift;
  logic [WIDTH-1:0]    q_shift;
  logic                last_step;

  // {ACC,Q} after one add-and-shift step. The adder carry-out becomes the
  // new accumulator MSB, so a full WIDTH+1-bit partial sum is never truncated.
  assign acc_shift = {add_cout, add_sum[WIDTH-1:1]};
  assign q_shift   = {add_sum[0], q[WIDTH-1:1]};
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  assign add_cin = 1'b0;
  assign product = product_reg;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode. busy/done depend only on the registered
  // state, so start never reaches them combinationally.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    add_a      = '0;
    add_b      = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        add_a = acc;
        add_b = q[0] ? m_reg : '0;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers. Operands are captured only on acceptance, so later
  // changes on a/b cannot disturb a running multiply. The product loads from
  // the shifted values on the final step, not from the registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_reg       <= '0;
      acc         <= '0;
      q           <= '0;
      cnt         <= '0;
      product_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            m_reg <= a;
            q     <= b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_shift;
          q   <= q_shift;
          cnt <= cnt + CNT_W'(1);
          if (last_step) begin
            product_reg <= {acc_shift, q_shift};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_mult_ctrl
//
// Self-checking bench for alu_mult_ctrl. It uses a WIDTH=4 instance for the
// main checks and a WIDTH=8 instance for a wide spot check. Each instance has
// a behavioural adder.
//
// Expected values come from plain arithmetic:
//   - the product is a*b;
//   - in RUN step k, the adder sees operand A = (a * (b mod 2^k)) >> k;
//   - in RUN step k, the adder sees operand B = b[k] ? a : 0.
// ---------------------------------------------------------------------------
module tb_alu_mult_ctrl;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;

  logic           start8;
  logic [7:0]     a8;
  logic [7:0]     b8;
  logic           busy8;
  logic           done8;
  logic [15:0]    product8;
  logic [7:0]     add_a8;
  logic [7:0]     add_b8;
  logic           add_cin8;
  logic [7:0]     add_sum8;
  logic           add_cout8;

  int checks = 0;
  int errors = 0;

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  // Behavioural stand-ins for the shared ripple adders
  assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign {add_cout8, add_sum8} = {1'b0, add_a8} + {1'b0, add_b8} + {8'b0, add_cin8};

  alu_mult_ctrl #(.WIDTH(W)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  alu_mult_ctrl #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start8),
    .a        (a8),
    .b        (b8),
    .busy     (busy8),
    .done     (done8),
    .product  (product8),
    .add_a    (add_a8),
    .add_b    (add_b8),
    .add_cin  (add_cin8),
    .add_sum  (add_sum8),
    .add_cout (add_cout8)
  );

  // Single comparison point: count it, report any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One complete multiply, called at a falling edge while idle. It walks every
  // RUN cycle against the reference, then the done cycle, then the return to
  // idle, and optionally watches the product hold for extra cycles.
  task automatic applyStimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                               input int hold_cycles);
    int exp_prod;
    int low;
    exp_prod = int'(op_a) * int'(op_b);
    a = op_a;
    b = op_b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    for (int k = 0; k < W; k++) begin
      low = int'(op_b) % (1 << k);
      checkOutput("run_busy", busy, 1);
      checkOutput("run_done", done, 0);
      checkOutput("run_add_a", add_a, (int'(op_a) * low) >> k);
      checkOutput("run_add_b", add_b, op_b[k] ? 32'(op_a) : 32'd0);
      checkOutput("run_add_cin", add_cin, 0);
      @(negedge clk);
    end
    checkOutput("done_pulse", done, 1);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_product", product, exp_prod);
    checkOutput("done_add_a", add_a, 0);
    checkOutput("done_add_b", add_b, 0);
    @(negedge clk);
    checkOutput("idle_done", done, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_product", product, exp_prod);
    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clk);
      checkOutput("hold_product", product, exp_prod);
      checkOutput("hold_done", done, 0);
    end
  endtask

  // Main sequence
  initial begin
    int done_count;
    int cyc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_product", product, 0);
    checkOutput("reset_add_a", add_a, 0);
    checkOutput("reset_add_b", add_b, 0);
    checkOutput("reset_add_cin", add_cin, 0);
    rst_n = 1'b1;

    // Directed cases
    applyStimulus(4'b1100, 4'b0001, 10);
    applyStimulus(4'd15, 4'd15, 0);
    applyStimulus(4'd0, 4'd9, 0);
    applyStimulus(4'd9, 4'd0, 0);

    // start held high: back-to-back operations every W+2 cycles,
    // operand change mid-run only affects the next operation
    done_count = 0;
    a = 4'd3;
    b = 4'd5;
    start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 2) begin
        a = 4'd7;
        b = 4'd6;
      end
      checkOutput("held_exclusive", busy & done, 0);
      if (done) begin
        done_count++;
        checkOutput("held_done_cycle", c, (W + 2) * done_count - 1);
        checkOutput("held_product", product, (done_count == 1) ? 15 : 42);
      end
    end
    start = 1'b0;
    checkOutput("held_done_count", done_count, 3);

    // Reset during the second RUN cycle aborts without a done pulse
    a = 4'd13;
    b = 4'd11;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_product", product, 0);
    checkOutput("abort_add_a", add_a, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput("abort_no_done", done, 0);
      checkOutput("abort_no_busy", busy, 0);
    end
    applyStimulus(4'd13, 4'd11, 0);

    // Exhaustive operand sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        applyStimulus(W'(i), W'(j), 0);
      end
    end

    // Randomised operations with random hold lengths
    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      applyStimulus(ra, rb, int'($urandom_range(0, 3)));
    end

    // Wide instance: 255 x 255, bounded wait for done
    a8 = 8'd255;
    b8 = 8'd255;
    start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("w8_latency", cyc, 9);
    checkOutput("w8_product", product8, 65025);
    checkOutput("w8_busy", busy8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mult_ctrl.md
# alu_mult_ctrl

- Sequential shift-and-add multiplier controller for the ALU.
- Drives one external WIDTH-bit ripple adder (the team's full-adder chain) through an explicit adder port, one add per cycle for WIDTH cycles.
- Produces a 2·WIDTH-bit unsigned product under a start/busy/done handshake.
- Sits between the ALU operation decoder and the shared adder instance.

## Interface
- WIDTH, default 4: operand width in bits; product width is 2·WIDTH.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- start  input  1  request; accepted only in IDLE.
- a  input  WIDTH  multiplicand; captured on start acceptance.
- b  input  WIDTH  multiplier; captured on start acceptance.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; product valid.
- product  output  2·WIDTH  last completed result; held until the next completion.
- add_a  output  WIDTH  adder operand A (accumulator).
- add_b  output  WIDTH  adder operand B (multiplicand or zero).
- add_cin  output  1  adder carry-in; constant 0.
- add_sum  input  WIDTH  adder sum, combinational from add_a/add_b/add_cin.
- add_cout  input  1  adder carry-out.

## Operation
- Internal registers:
  - M: multiplicand, WIDTH bits.
  - ACC: high half, WIDTH bits.
  - Q: low half / multiplier, WIDTH bits.
  - CNT: cycle counter, clog2(WIDTH)+1 bits.
  - product register.
  - state register.
- State machine, encoding free:
  - IDLE -> RUN when start=1. On that edge: M<=a, Q<=b, ACC<=0, CNT<=0.
  - RUN:
    - add_a=ACC.
    - add_b = M when Q[0]=1, else 0.
    - Each edge: {ACC,Q} <= {add_cout, add_sum, Q} >> 1, i.e. ACC<={add_cout, add_sum[WIDTH-1:1]} and Q<={add_sum[0], Q[WIDTH-1:1]}; CNT<=CNT+1.
    - When CNT=WIDTH-1: same shift, then product<={shifted ACC, shifted Q}; state -> DONE.
  - DONE -> IDLE unconditionally after one cycle.
- Arithmetic:
  - Unsigned only.
  - Adder carry-out becomes the MSB of the shifted accumulator, so no bit is lost.
  - Maximum result (2^WIDTH-1)^2 fits in 2·WIDTH bits.
- Adder port outputs:
  - In IDLE/DONE: add_a=0, add_b=0.
  - add_cin=0 in every state.
- start handling:
  - Ignored in RUN and DONE.
  - Changes to a/b after acceptance have no effect.
- Reset (rst_n=0 at an edge), from any state including mid-RUN:
  - Outputs: state=IDLE, busy=0, done=0, product=0.
  - Registers: ACC, Q, M and CNT all cleared to 0.
  - The aborted operation produces no done pulse.
  - Reset has priority over start.

## Timing
- Start accepted at edge E0 (state IDLE, start=1, rst_n=1).
- busy=1 for the WIDTH cycles between edges E0 and E0+WIDTH.
- The product register loads at edge E0+WIDTH.
- done=1 for exactly the cycle between E0+WIDTH and E0+WIDTH+1; product is valid in that cycle and stays stable afterward.
- busy and done are never high together. Both are registered state decodes, with no combinational path from start.
- Earliest next acceptance is edge E0+WIDTH+2, the first edge in IDLE. With start held high, operations repeat every WIDTH+2 cycles.
- Combinational path: registers -> add_a/add_b -> external adder -> add_sum/add_cout -> register inputs, within one cycle.

## Test plan
- Reset, then a=4'b1100, b=4'b0001, start one cycle:
  - busy high 4 cycles, then done pulse.
  - product=8'd12, held stable 10+ cycles after done.
- a=15, b=15 -> product=8'd225 (8'hE1). Checks carry-out capture every cycle.
- a=0, b=9 -> 0; a=9, b=0 -> 0. add_b=0 on every RUN cycle of the second case (Q[0]=0 throughout).
- start held high continuously with a=3, b=5:
  - done pulses every 6 cycles, product=15 each time.
  - a/b changed to 7/6 while busy: current result still 15; next result 42.
- rst_n=0 for one edge during the 2nd RUN cycle of a=13, b=11:
  - busy/done/product all 0 next cycle, no done pulse.
  - Fresh start with 13×11 gives 143.
- Exhaustive 256-pair sweep for WIDTH=4 against a reference multiply. Also a WIDTH=8 spot check: 255×255=65025.
